muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit that takes over MULT/MULTU/DIV/DIVU from the single-cycle ALU and owns the HI/LO registers read by MFHI/MFLO. It sits downstream of the register file read ports, beside the ALU. Its `busy` output is the stall condition the controller uses to hold the PC while a HI/LO read or a new mul/div is pending. It uses one shared 32-step shift/add-subtract datapath.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch request; sampled only while `busy`=0.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  WIDTH  rs operand (multiplicand / dividend).
- `b`  in  WIDTH  rt operand (multiplier / divisor).
- `hi_we`, `lo_we`  in  1 each  MTHI/MTLO write strobes.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight.
- `done`  out  1  one-cycle pulse when HI/LO have been updated by an operation.
- `divzero`  out  1  one-cycle pulse coincident with `done` for DIV/DIVU with `b`=0.
- `hi`, `lo`  out  WIDTH each  architectural HI/LO.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE, `start`=1 at edge E0:
  - Latch `op`.
  - Latch |a| and |b| (plain values for MULTU/DIVU).
  - Latch the sign flags.
  - Clear the 6-bit step counter and go to CALC.
- CALC, multiply (one step per edge):
  - If multiplier LSB=1, add the multiplicand into the upper half of a 2·WIDTH accumulator, keeping the carry.
  - Shift the accumulator right by one.
- CALC, divide (restoring, one step per edge):
  - Shift {remainder, quotient} left by one.
  - Trial-subtract the divisor from the remainder.
  - If no borrow, keep the difference and set quotient LSB=1.
- CALC lasts exactly WIDTH edges (E1..E32); the counter reaching WIDTH-1 moves the FSM to FINISH.
- FINISH (edge E33):
  - MULT: if the operand signs differ, negate the 64-bit product. HI=upper half, LO=lower half.
  - DIV: LO=quotient, negated if the signs differ. HI=remainder, taking the sign of the dividend.
  - MULTU/DIVU: no fixup.
  - Assert `done` and return to IDLE.
- -2^31 / -1 (DIV): LO=0x80000000, HI=0. No trap.
- Divide by zero (`b`=0, DIV or DIVU):
  - Full latency still runs.
  - HI/LO are left unchanged.
  - `divzero` pulses with `done`.
- MTHI/MTLO:
  - Honoured only in IDLE: `hi_we` loads HI from `wdata`, `lo_we` loads LO from `wdata`, on the next edge.
  - Ignored while `busy`=1.
- `start` while `busy`=1 is ignored; the in-flight operation is unaffected.
- `start` and `hi_we`/`lo_we` in the same IDLE cycle: the MTHI/MTLO write takes effect at E0, and the operation then overwrites HI/LO at E33.
- Operands are sampled only at E0; later changes on `a`/`b` have no effect.

## Timing
- Reset (`reset_n`=0, asynchronous, at any time including mid-CALC):
  - State goes to IDLE.
  - `hi`=`lo`=0, `busy`=0, `done`=0, `divzero`=0.
  - The pending operation is discarded.
- `busy`: 1 from just after E0 through E33; 0 again after E33.
- `done`/`divzero`: high for the single cycle following E33.
- HI/LO updated at E33, so MFHI/MFLO are valid in the cycle after E33. Total latency is 33 edges from the sampling edge.
- Back-to-back operations: a `start` asserted in the cycle after E33 (while `done`=1) is accepted. Throughput is one operation per 34 cycles.
- `hi`/`lo` are driven straight from flops; there is no combinational path from inputs to outputs except none.
- The accumulator is 2·WIDTH+1 bits to hold the add carry. The counter wraps never; it is cleared on each start.

## Test plan
- MULT, a=7, b=0xFFFFFFFD -> after 33 edges: HI=0xFFFFFFFF, LO=0xFFFFFFEB, `done` pulse, `busy` low.
- MULTU, a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x1234, MTLO 0x5678, then DIVU a=100, b=0 -> HI=0x1234, LO=0x5678 unchanged, `divzero`=1 and `done`=1 in the same cycle.
- DIVU 100/7 started, with `start` (MULTU 3*3) and `hi_we` pulsed at CALC step 10 -> both ignored; result LO=14, HI=2 at E33.
- MULTU started, `reset_n` dropped at CALC step 5 -> `busy`=0, HI=LO=0 immediately. A new MULTU 3*3 after release -> LO=9, HI=0 after 33 edges.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// A single shared accumulator is used for both operations. Multiply adds the
// multiplicand and shifts right; divide shifts left and does a restoring
// trial subtract. Signed operations run on magnitudes, and the sign is
// corrected in FINISH.
//
// state  | meaning
// IDLE   | waiting for start; MTHI/MTLO writes honoured
// CALC   | WIDTH shift/add or shift/subtract steps
// FINISH | sign fixup, HI/LO update, done/divzero pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  localparam int CW = 6;

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               sa_q, sa_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               divzero_q, divzero_d;

  logic               signed_op, sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH:0]   mul_step;
  logic [WIDTH:0]     div_rem_sh, div_diff;
  logic               div_ok;
  logic [2*WIDTH:0]   div_step;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  // One datapath step for each operation, plus the signed operand and result fixups
  always_comb begin
    signed_op  = ~op[0];
    sa         = signed_op & a[WIDTH-1];
    sb         = signed_op & b[WIDTH-1];
    abs_a      = sa ? (~a + 1'b1) : a;
    abs_b      = sb ? (~b + 1'b1) : b;

    // acc_q[2*WIDTH] holds the add carry; it is always shifted back out as zero
    mul_sum    = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_step   = {1'b0, mul_sum, acc_q[WIDTH-1:1]};

    // The remainder, shifted left, takes in the next dividend bit
    div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff   = div_rem_sh - {1'b0, opnd_q};
    div_ok     = (div_rem_sh >= {1'b0, opnd_q});
    div_step   = div_ok ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                        : {div_rem_sh, acc_q[WIDTH-2:0], 1'b0};

    prod       = acc_q[2*WIDTH-1:0];
    prod_fix   = neg_q ? (~prod + 1'b1) : prod;
    quo        = acc_q[WIDTH-1:0];
    rem        = acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state logic for the FSM, the datapath and HI/LO
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    sa_d      = sa_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          is_div_d = op[1];
          neg_d    = sa ^ sb;
          sa_d     = sa;
          dz_d     = op[1] & (b == '0);
          cnt_d    = '0;
          if (op[1]) begin
            acc_d  = {{(WIDTH+1){1'b0}}, abs_a};
            opnd_d = abs_b;
          end else begin
            acc_d  = {{(WIDTH+1){1'b0}}, abs_b};
            opnd_d = abs_a;
          end
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) state_d = FINISH;
      end
      FINISH: begin
        if (is_div_q) begin
          if (!dz_q) begin
            lo_d = neg_q ? (~quo + 1'b1) : quo;
            hi_d = sa_q  ? (~rem + 1'b1) : rem;
          end
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d    = 1'b1;
        divzero_d = is_div_q & dz_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight operation and clears HI/LO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      sa_q      <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      sa_q      <= sa_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign divzero = divzero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, exact latency,
// divide-by-zero, MTHI/MTLO, ignored start during busy, and mid-operation reset.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hi_we, lo_we;
  logic [31:0] wdata;
  logic        busy, done, divzero;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .divzero(divzero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive start before edge E0, then release it just after E0
  task automatic launch(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb);
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    @(posedge clk);
    #1 start = 1'b0;
    a = 32'hA5A5A5A5; b = 32'h5A5A5A5A;
  endtask

  // Full operation with exact-latency checks at E32, E33 and the cycle after
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] ehi,
                        input logic [31:0] elo, input logic edz);
    launch(o, va, vb);
    chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
    repeat (32) @(posedge clk);
    #1;
    chk({tag, ".busy_e32"}, 32'(busy), 32'd1);
    chk({tag, ".done_e32"}, 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".divzero"}, 32'(divzero), 32'(edz));
    chk({tag, ".busy_e33"}, 32'(busy), 32'd0);
    chk({tag, ".hi"}, hi, ehi);
    chk({tag, ".lo"}, lo, elo);
    @(posedge clk);
    #1;
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.divzero", 32'(divzero), 32'd0);
    chk("rst.hi", hi, 32'd0);
    chk("rst.lo", lo, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);

    run_op("mult_7_m3", 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu_7_m2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0, 1'b0);

    // MTHI/MTLO, then a divide by zero must leave both untouched
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clk);
    #1 hi_we = 1'b0;
    chk("mthi", hi, 32'h1234);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h5678;
    @(posedge clk);
    #1 lo_we = 1'b0;
    chk("mtlo", lo, 32'h5678);
    run_op("divu_by0", 2'b11, 32'd100, 32'd0, 32'h1234, 32'h5678, 1'b1);

    // start and hi_we during CALC are ignored
    launch(2'b11, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b01; a = 32'd3; b = 32'd3;
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0;
    chk("ign.hi_mid", hi, 32'h1234);
    repeat (21) @(posedge clk);
    #1;
    chk("ign.busy_e32", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("ign.done", 32'(done), 32'd1);
    chk("ign.lo", lo, 32'd14);
    chk("ign.hi", hi, 32'd2);

    // Asynchronous reset in the middle of CALC
    launch(2'b01, 32'd1000, 32'd1000);
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy), 32'd0);
    chk("arst.hi", hi, 32'd0);
    chk("arst.lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("multu_3x3", 2'b01, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
